// File: rtl/rf_multiport.sv
// rf_multiport: parametrised register file.
//   - DEPTH words of WIDTH bits
//   - one synchronous write port
//   - two combinational read ports (A, B)
//   - per-entry valid bitmap and a synchronous bulk clear
//   - asynchronous active-high reset
// Optional feature (macro RF_BYPASS_EN): a read port whose address matches a
// committing write returns wr_data in the same cycle. Without the macro, a
// read-during-write returns the pre-write value.
//
// Write port handshake: there is no ready; the port is always able to accept.
// wr_en is sampled on every rising edge. A write commits when wr_en=1, clr=0
// and it is not dropped by ZERO_REG. wr_ack is high for exactly the one cycle
// following each committed write and low otherwise (including after a clr or
// a dropped write).
module rf_multiport #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    output logic [DEPTH-1:0] valid,
    output logic             wr_ack
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic             wr_ack_q;
    logic             wr_drop;
    logic             wr_commit;

    // Decide whether the write presented this cycle will land in the array.
    always_comb begin
        wr_drop   = (ZERO_REG != 0) && (wr_addr == '0);
        wr_commit = wr_en && !clr && !wr_drop;
    end

    // Storage, valid bitmap and ack pulse; clr outranks a simultaneous write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid_q  <= '0;
            wr_ack_q <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid_q  <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            if (wr_commit) begin
                mem[wr_addr]     <= wr_data;
                valid_q[wr_addr] <= 1'b1;
            end
            wr_ack_q <= wr_commit;
        end
    end

    // Read port A: array lookup, zero register, optional write bypass.
    always_comb begin
        rd_data_a = mem[rd_addr_a];
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
            rd_data_a = '0;
        end
`ifdef RF_BYPASS_EN
        if (wr_commit && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
`endif
    end

    // Read port B: identical to port A on its own address.
    always_comb begin
        rd_data_b = mem[rd_addr_b];
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
            rd_data_b = '0;
        end
`ifdef RF_BYPASS_EN
        if (wr_commit && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
`endif
    end

    assign valid  = valid_q;
    assign wr_ack = wr_ack_q;

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: checks rf_multiport against a reference model.
// Two instances share all inputs: one with ZERO_REG=0 and one with ZERO_REG=1.
module tb_rf_multiport;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int AW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          clr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;

    logic [W-1:0]  rda [2];
    logic [W-1:0]  rdb [2];
    logic [D-1:0]  vld [2];
    logic          ack [2];

    rf_multiport #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) dut (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_data_a(rda[0]),
        .rd_addr_b(rb), .rd_data_b(rdb[0]),
        .valid(vld[0]), .wr_ack(ack[0])
    );

    rf_multiport #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .clr(clr), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(ra), .rd_data_a(rda[1]),
        .rd_addr_b(rb), .rd_data_b(rdb[1]),
        .valid(vld[1]), .wr_ack(ack[1])
    );

    // ---------------- reference model ----------------
    logic [W-1:0] m_mem [2][D];
    logic [D-1:0] m_valid [2];
    logic         m_ack [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < D; i++) m_mem[z][i] = '0;
            m_valid[z] = '0;
            m_ack[z]   = 1'b0;
        end
    endtask

    // Effect of one rising edge on the stored state of each instance.
    task automatic model_edge();
        for (int z = 0; z < 2; z++) begin
            if (clr) begin
                for (int i = 0; i < D; i++) m_mem[z][i] = '0;
                m_valid[z] = '0;
                m_ack[z]   = 1'b0;
            end else if (wr_en && !(z == 1 && int'(wr_addr) == 0)) begin
                m_mem[z][wr_addr]   = wr_data;
                m_valid[z][wr_addr] = 1'b1;
                m_ack[z]            = 1'b1;
            end else begin
                m_ack[z] = 1'b0;
            end
        end
    endtask

    // Value a read port should show right now.
    function automatic logic [W-1:0] exp_rd(input int z, input logic [AW-1:0] a);
`ifdef RF_BYPASS_EN
        if (wr_en && !clr && !(z == 1 && int'(wr_addr) == 0) && a == wr_addr)
            return wr_data;
`endif
        if (z == 1 && int'(a) == 0) return '0;
        return m_mem[z][a];
    endfunction

    task automatic check_all(input string tag);
        for (int z = 0; z < 2; z++) begin
            check($sformatf("%s.z%0d.rda", tag, z), 32'(rda[z]), 32'(exp_rd(z, ra)));
            check($sformatf("%s.z%0d.rdb", tag, z), 32'(rdb[z]), 32'(exp_rd(z, rb)));
            check($sformatf("%s.z%0d.valid", tag, z), 32'(vld[z]), 32'(m_valid[z]));
            check($sformatf("%s.z%0d.ack", tag, z), 32'(ack[z]), 32'(m_ack[z]));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are set just after a rising edge; reads are checked before the
    // next edge and the full state just after it.
    task automatic cycle(input string tag);
        #2;
        check_all({tag, ".pre"});
        @(posedge clk);
        model_edge();
        #1;
        check_all({tag, ".post"});
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d; clr = 1'b0;
        cycle("write");
        wr_en = 1'b0;
    endtask

    task automatic idle();
        wr_en = 1'b0; clr = 1'b0;
        cycle("idle");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; clr = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0; ra = '0; rb = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Preload every entry with F, then reset between edges.
        for (int i = 0; i < D; i++) write(AW'(i), 4'hF);
        ra = 2'd3; rb = 2'd2;
        check("preload.ack", 32'(ack[0]), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_rst.rda", 32'(rda[0]), 32'h0);
        check("async_rst.rdb", 32'(rdb[0]), 32'h0);
        check("async_rst.valid", 32'(vld[0]), 32'h0);
        check("async_rst.ack", 32'(ack[0]), 32'h0);
        check_all("async_rst");

        // A write presented while reset is held is discarded.
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h5;
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        reset = 1'b0; wr_en = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        check_all("rst_release");

        // Write A to address 2.
        ra = 2'd2; rb = 2'd0;
        write(2'd2, 4'hA);
        check("wr.ack", 32'(ack[0]), 32'd1);
        check("wr.valid", 32'(vld[0]), 32'h4);
        check("wr.rda", 32'(rda[0]), 32'hA);
        idle();
        check("wr.ack_drop", 32'(ack[0]), 32'd0);

        // Dual read, distinct then same address.
        write(2'd1, 4'h3);
        write(2'd3, 4'hC);
        ra = 2'd1; rb = 2'd3;
        #1;
        check("dual.rda", 32'(rda[0]), 32'h3);
        check("dual.rdb", 32'(rdb[0]), 32'hC);
        ra = 2'd3;
        #1;
        check("same.rda", 32'(rda[0]), 32'hC);
        check("same.rdb", 32'(rdb[0]), 32'hC);
        idle();

        // Read-during-write on address 1.
        write(2'd1, 4'h2);
        ra = 2'd1; rb = 2'd1;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h9;
        #2;
`ifdef RF_BYPASS_EN
        check("rdw.pre", 32'(rda[0]), 32'h9);
`else
        check("rdw.pre", 32'(rda[0]), 32'h2);
`endif
        cycle("rdw");
        wr_en = 1'b0;
        #1;
        check("rdw.post", 32'(rda[0]), 32'h9);

        // clr together with a write: clr wins.
        clr = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h5;
        ra = 2'd0; rb = 2'd3;
        cycle("clr");
        clr = 1'b0; wr_en = 1'b0;
        #1;
        check("clr.rda", 32'(rda[0]), 32'h0);
        check("clr.rdb", 32'(rdb[0]), 32'h0);
        check("clr.valid", 32'(vld[0]), 32'h0);
        check("clr.ack", 32'(ack[0]), 32'h0);

        // Zero register: write 7 to address 0.
        ra = 2'd0; rb = 2'd0;
        write(2'd0, 4'h7);
        check("zreg.rda", 32'(rda[1]), 32'h0);
        check("zreg.valid0", 32'(vld[1][0]), 32'h0);
        check("zreg.ack", 32'(ack[1]), 32'h0);
        check("zreg.plain_rda", 32'(rda[0]), 32'h7);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            wr_en   = 1'($urandom_range(0, 1));
            clr     = ($urandom_range(0, 15) == 0);
            wr_addr = AW'($urandom_range(0, D - 1));
            wr_data = W'($urandom);
            ra      = AW'($urandom_range(0, D - 1));
            rb      = AW'($urandom_range(0, D - 1));
            cycle("rand");
        end
        wr_en = 1'b0; clr = 1'b0;
        for (int n = 0; n < 3; n++) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised register file: DEPTH words of WIDTH bits each.
- One synchronous write port and two combinational read ports (A, B).
- Per-entry valid bitmap and a synchronous bulk clear.
- Generalises the single-select fixed-width register; serves as the operand store for the datapath and ALU labs.

Parameters:
- WIDTH, 4, bits per register word (1..32)
- DEPTH, 4, number of registers (power of two, 2..32)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- ZERO_REG, 0, when 1, entry 0 is hardwired to zero and writes to it are ignored

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- clr  input  1  synchronous clear of all entries and valid bits
- wr_en  input  1  write enable
- wr_addr  input  AW  write address
- wr_data  input  WIDTH  write data
- rd_addr_a  input  AW  read port A address
- rd_data_a  output  WIDTH  read port A data
- rd_addr_b  input  AW  read port B address
- rd_data_b  output  WIDTH  read port B data
- valid  output  DEPTH  bit i = entry i has been written since the last reset or clr
- wr_ack  output  1  registered pulse: the previous cycle's write was committed

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). Asserting reset immediately forces:
  - every entry to 0
  - valid to 0
  - wr_ack to 0
- This holds regardless of clk. Deassertion is taken on a clk edge; the first write is accepted on the first rising edge with reset low.
- Write, on a rising edge with wr_en=1, clr=0:
  - mem[wr_addr] <= wr_data
  - valid[wr_addr] <= 1
  - wr_ack <= 1
- If ZERO_REG=1 and wr_addr=0: the write is dropped, valid[0] stays 0 and wr_ack <= 0.
- Otherwise wr_ack <= 0, so it is high for exactly one cycle per committed write.
- Clear: clr=1 on a rising edge zeroes all entries and valid and sets wr_ack <= 0. clr has priority over a simultaneous wr_en, so the write is lost.
- Read:
  - rd_data_a = mem[rd_addr_a] and rd_data_b = mem[rd_addr_b], combinational, zero latency.
  - Both ports may address the same entry, and both return the same value.
  - With ZERO_REG=1, a read of address 0 always returns 0.
- Read-during-write (same address, same cycle), without the bypass: the read returns the old value; the new value is visible after the edge.
- Out-of-range addresses cannot occur because DEPTH is a power of two, so every AW-bit address is valid.
- Reset mid-operation discards any write presented in that cycle.
- Entries hold their value indefinitely while wr_en=0 and clr=0.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a read port whose address equals wr_addr while wr_en=1 and clr=0 (and the write is not dropped by ZERO_REG) returns wr_data combinationally in the same cycle.
- Not defined: read-during-write returns the pre-write value, as stated under Behaviour.
- Write timing, valid and wr_ack are identical in both builds.

Test Plan:
- Async reset: with WIDTH=4, DEPTH=4, preload all entries with 4'hF, assert reset between clock edges -> all read data 0, valid=4'b0000, wr_ack=0 before the next edge.
- Write/read: write 4'hA to addr 2 -> next cycle wr_ack=1, valid=4'b0100, rd_data_a at addr 2 = 4'hA; cycle after that wr_ack=0.
- Dual read: mem[1]=4'h3, mem[3]=4'hC, rd_addr_a=1, rd_addr_b=3 -> rd_data_a=4'h3 and rd_data_b=4'hC in the same cycle; with both addresses set to 3, both ports read 4'hC.
- clr priority: assert clr=1 together with wr_en=1, addr 0, data 4'h5 -> after the edge, all entries 0, valid=0, wr_ack=0.
- Read-during-write: mem[1]=4'h2, write 4'h9 to addr 1 with rd_addr_a=1 -> pre-edge rd_data_a=4'h2 without RF_BYPASS_EN, 4'h9 with it; post-edge 4'h9 in both builds.
- ZERO_REG=1: write 4'h7 to addr 0 -> rd_data at addr 0 = 0, valid[0]=0, wr_ack=0.
